// File: rtl/adc_sample_accumulator_if.sv
// Handshake bundle between the measurement controller/ADC capture side and the
// sample accumulator. The master drives start, samples and ready; the slave returns the sum.
interface adc_sample_accumulator_if #(
  parameter int ADC_WIDTH = 12
);
  logic                        start;
  logic                        adc_valid;
  logic signed [ADC_WIDTH-1:0] adc_data;
  logic                        acc_valid;
  logic                        acc_ready;
  logic signed [ADC_WIDTH+3:0] acc_out;
  logic                        busy;
  logic                        clip;

  modport master (
    output start, adc_valid, adc_data, acc_ready,
    input  acc_valid, acc_out, busy, clip
  );

  modport slave (
    input  start, adc_valid, adc_data, acc_ready,
    output acc_valid, acc_out, busy, clip
  );
endinterface

// File: rtl/adc_sample_accumulator.sv
// Sums ACC_SAMPLES signed ADC samples per start pulse and holds the result on a valid/ready output.
// Optional sticky rail-clip flag is enabled by defining ADC_ACC_CLIP_DETECT_EN.
module adc_sample_accumulator #(
  parameter int ADC_WIDTH   = 12,
  parameter int ACC_SAMPLES = 8
) (
  input logic                     clk,
  input logic                     rst,
  adc_sample_accumulator_if.slave bus
);

  localparam int SUM_WIDTH = ADC_WIDTH + 4;
  localparam int CNT_WIDTH = 5;
  localparam logic signed [ADC_WIDTH-1:0] MIN_CODE   = {1'b1, {(ADC_WIDTH-1){1'b0}}};
  localparam logic signed [ADC_WIDTH-1:0] CLAMP_CODE = {1'b1, {(ADC_WIDTH-2){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]        LAST_COUNT = CNT_WIDTH'(ACC_SAMPLES - 1);

  generate
    if (ACC_SAMPLES < 2 || ACC_SAMPLES > 16) begin : g_bad_samples
      $error("adc_sample_accumulator: ACC_SAMPLES must be in 2..16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                       state_q;
  logic [CNT_WIDTH-1:0]         count_q;
  logic signed [SUM_WIDTH-1:0]  sum_q;
  logic signed [SUM_WIDTH-1:0]  accOut_q;
  logic                         accValid_q;
  logic                         busy_q;

  logic                         startAccept;
  logic                         sampleAccept;
  logic                         lastSample;
  logic signed [ADC_WIDTH-1:0]  sampleClamped;
  logic signed [SUM_WIDTH-1:0]  sumNext;

  assign startAccept  = (state_q == IDLE) && bus.start;
  assign sampleAccept = (state_q == ACCUM) && bus.adc_valid;
  assign lastSample   = sampleAccept && (count_q == LAST_COUNT);

  // The most negative code is pulled in by one LSB so full scale is symmetric.
  always_comb begin
    sampleClamped = bus.adc_data;
    if (bus.adc_data == MIN_CODE) sampleClamped = CLAMP_CODE;
    sumNext = sum_q + {{(SUM_WIDTH-ADC_WIDTH){sampleClamped[ADC_WIDTH-1]}}, sampleClamped};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      sum_q      <= '0;
      accOut_q   <= '0;
      accValid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= ACCUM;
            sum_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        ACCUM: begin
          if (bus.adc_valid) begin
            sum_q   <= sumNext;
            count_q <= count_q + 1'b1;
            if (lastSample) begin
              accOut_q   <= sumNext;
              accValid_q <= 1'b1;
              state_q    <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.acc_ready) begin
            accValid_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.acc_out   = accOut_q;
  assign bus.acc_valid = accValid_q;
  assign bus.busy      = busy_q;

`ifdef ADC_ACC_CLIP_DETECT_EN
  localparam logic signed [ADC_WIDTH-1:0] MAX_CODE = {1'b0, {(ADC_WIDTH-1){1'b1}}};

  logic clipFlag_q;
  logic clipOut_q;
  logic sampleAtRail;

  // Rails are judged on the raw code, before the symmetric clamp.
  assign sampleAtRail = (bus.adc_data == MAX_CODE) || (bus.adc_data == MIN_CODE);

  always_ff @(posedge clk) begin
    if (rst) begin
      clipFlag_q <= 1'b0;
      clipOut_q  <= 1'b0;
    end else begin
      if (startAccept) begin
        clipFlag_q <= 1'b0;
      end else if (sampleAccept) begin
        clipFlag_q <= clipFlag_q | sampleAtRail;
      end
      if (lastSample) clipOut_q <= clipFlag_q | sampleAtRail;
    end
  end

  assign bus.clip = clipOut_q;
`else
  assign bus.clip = 1'b0;
`endif

endmodule

// File: tb/tb_adc_sample_accumulator.sv
// Directed bench for adc_sample_accumulator: sums, rail clamp, stalls, backpressure,
// ignored start/adc_valid and mid-measurement reset.
module tb_adc_sample_accumulator;

  logic clk;
  logic rst;
  int   testCount;
  int   failCount;

`ifdef ADC_ACC_CLIP_DETECT_EN
  localparam logic RAIL_CLIP = 1'b1;
`else
  localparam logic RAIL_CLIP = 1'b0;
`endif

  adc_sample_accumulator_if #(.ADC_WIDTH(12)) bus ();

  adc_sample_accumulator #(
    .ADC_WIDTH  (12),
    .ACC_SAMPLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at a falling edge, let the rising edge act, return at the next falling edge.
  task automatic applyStimulus(input logic s, input logic v, input logic signed [11:0] d, input logic r);
    bus.start     = s;
    bus.adc_valid = v;
    bus.adc_data  = d;
    bus.acc_ready = r;
    @(negedge clk);
  endtask

  task automatic feedSamples(input logic signed [11:0] d, input int n, input logic r);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, d, r);
  endtask

  task automatic checkOutput(input string tag, input logic expValid, input logic signed [15:0] expOut,
                             input logic expBusy, input logic expClip);
    testCount++;
    assert (bus.acc_valid === expValid) else begin
      failCount++;
      $error("[TB] FAIL %s acc_valid: got %b expected %b", tag, bus.acc_valid, expValid);
    end
    testCount++;
    assert (bus.acc_out === expOut) else begin
      failCount++;
      $error("[TB] FAIL %s acc_out: got %0d expected %0d", tag, bus.acc_out, expOut);
    end
    testCount++;
    assert (bus.busy === expBusy) else begin
      failCount++;
      $error("[TB] FAIL %s busy: got %b expected %b", tag, bus.busy, expBusy);
    end
    testCount++;
    assert (bus.clip === expClip) else begin
      failCount++;
      $error("[TB] FAIL %s clip: got %b expected %b", tag, bus.clip, expClip);
    end
  endtask

  initial begin
    testCount     = 0;
    failCount     = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.adc_valid = 1'b0;
    bus.adc_data  = '0;
    bus.acc_ready = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 12'sd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 12'sd0, 1'b0);
    checkOutput("reset", 1'b0, 16'sd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Basic sum: 8 x +1000, single-cycle valid with ready held high
    applyStimulus(1'b1, 1'b0, 12'sd0, 1'b1);
    checkOutput("basic_start", 1'b0, 16'sd0, 1'b1, 1'b0);
    feedSamples(12'sd1000, 7, 1'b1);
    checkOutput("basic_7th", 1'b0, 16'sd0, 1'b1, 1'b0);
    feedSamples(12'sd1000, 1, 1'b1);
    checkOutput("basic_done", 1'b1, 16'sd8000, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 12'sd0, 1'b1);
    checkOutput("basic_after", 1'b0, 16'sd8000, 1'b0, 1'b0);

    // Positive rail
    applyStimulus(1'b1, 1'b0, 12'sd0, 1'b1);
    feedSamples(12'sd2047, 8, 1'b1);
    checkOutput("rail_pos", 1'b1, 16'sd16376, 1'b1, RAIL_CLIP);
    applyStimulus(1'b0, 1'b0, 12'sd0, 1'b1);

    // Negative rail, clamped to -2047 per sample
    applyStimulus(1'b1, 1'b0, 12'sd0, 1'b1);
    feedSamples(-12'sd2048, 8, 1'b1);
    checkOutput("rail_neg", 1'b1, -16'sd16376, 1'b1, RAIL_CLIP);
    applyStimulus(1'b0, 1'b0, 12'sd0, 1'b1);
    checkOutput("rail_neg_held", 1'b0, -16'sd16376, 1'b0, RAIL_CLIP);

    // Stalls: valid pattern 1,0,0 with samples 1..8; garbage data on idle cycles
    applyStimulus(1'b1, 1'b0, 12'sd0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 1'b1, 12'(i), 1'b1);
      if (i < 8) begin
        applyStimulus(1'b0, 1'b0, 12'sd99, 1'b1);
        applyStimulus(1'b0, 1'b0, 12'sd99, 1'b1);
      end
      if (i == 4) checkOutput("stall_mid", 1'b0, -16'sd16376, 1'b1, RAIL_CLIP);
    end
    checkOutput("stall_done", 1'b1, 16'sd36, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 12'sd0, 1'b1);

    // Backpressure: ready low 5 cycles, start in DONE ignored, including in the handshake cycle
    applyStimulus(1'b1, 1'b0, 12'sd0, 1'b0);
    feedSamples(12'sd10, 8, 1'b0);
    checkOutput("bp_done", 1'b1, 16'sd80, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus((i == 2), 1'b0, 12'sd0, 1'b0);
      checkOutput("bp_hold", 1'b1, 16'sd80, 1'b1, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 12'sd0, 1'b1);
    checkOutput("bp_xfer", 1'b0, 16'sd80, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 12'sd0, 1'b1);
    checkOutput("bp_no_restart", 1'b0, 16'sd80, 1'b0, 1'b0);

    // adc_valid in IDLE must not leak into the next sum
    feedSamples(12'sd500, 3, 1'b1);
    checkOutput("idle_valid", 1'b0, 16'sd80, 1'b0, 1'b0);

    // start pulsed alongside the 4th sample is ignored; 8 x 3 = 24
    applyStimulus(1'b1, 1'b0, 12'sd0, 1'b1);
    feedSamples(12'sd3, 3, 1'b1);
    applyStimulus(1'b1, 1'b1, 12'sd3, 1'b1);
    feedSamples(12'sd3, 4, 1'b1);
    checkOutput("start_ignored", 1'b1, 16'sd24, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 12'sd0, 1'b1);

    // Reset after 3 samples discards the measurement; then 8 x -5 = -40
    applyStimulus(1'b1, 1'b0, 12'sd0, 1'b1);
    feedSamples(12'sd100, 3, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 12'sd0, 1'b1);
    checkOutput("mid_reset", 1'b0, 16'sd0, 1'b0, 1'b0);
    rst = 1'b0;
    feedSamples(12'sd100, 5, 1'b1);
    checkOutput("post_reset_idle", 1'b0, 16'sd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 12'sd0, 1'b1);
    feedSamples(-12'sd5, 8, 1'b1);
    checkOutput("neg_sum", 1'b1, -16'sd40, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 12'sd0, 1'b1);
    checkOutput("neg_sum_after", 1'b0, -16'sd40, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
